// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter with optional burst hold. It drives a registered shared result bus.
// The bus is a one-hot AND-OR mux feeding an output register with a valid/ready handshake.
module shared_bus_arbiter #(
    parameter int  DATA_WIDTH = 8,
    parameter int  NUM_AGENTS = 4,
    parameter int  MAX_BURST  = 1,
    localparam int SRC_W      = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_AGENTS-1:0]            req_i,
    input  logic [NUM_AGENTS*DATA_WIDTH-1:0] data_i,
    output logic [NUM_AGENTS-1:0]            gnt_o,
    output logic                             bus_valid_o,
    output logic [DATA_WIDTH-1:0]            bus_data_o,
    output logic [SRC_W-1:0]                 bus_src_o,
    input  logic                             bus_ready_i
);
    localparam int               CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_AGENTS - 1);

    logic                  r_vld;
    logic [DATA_WIDTH-1:0] r_data;
    logic [SRC_W-1:0]      r_src;
    logic [SRC_W-1:0]      r_ptr;
    logic [SRC_W-1:0]      r_owner;
    logic                  r_own_vld;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_can_load;
    logic                  w_hold;
    logic                  w_gnt_any;
    logic [SRC_W-1:0]      w_gnt_idx;
    logic [SRC_W-1:0]      w_scan_idx;
    logic [NUM_AGENTS-1:0] w_gnt;
    logic [DATA_WIDTH-1:0] w_mux;

    assign w_can_load = !r_vld || bus_ready_i;
    assign w_hold     = r_own_vld && req_i[r_owner] && (r_cnt < CNT_MAX);

    // Scan from the highest offset down so the last hit is the first requester after r_ptr.
    always_comb begin
        int j;
        j          = 0;
        w_scan_idx = '0;
        for (int i = NUM_AGENTS - 1; i >= 0; i--) begin
            j = int'(r_ptr) + i;
            if (j >= NUM_AGENTS) j = j - NUM_AGENTS;
            if (req_i[SRC_W'(j)]) w_scan_idx = SRC_W'(j);
        end
    end

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_gnt     = '0;
        if (!reset && w_can_load && (req_i != '0)) begin
            w_gnt_any        = 1'b1;
            w_gnt_idx        = w_hold ? r_owner : w_scan_idx;
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_mux = '0;
        for (int i = 0; i < NUM_AGENTS; i++)
            w_mux = w_mux | (data_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_gnt[i]}});
    end

    // The burst count saturates: once exhausted, the owner only wins through the pointer scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld     <= 1'b0;
            r_data    <= '0;
            r_src     <= '0;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_own_vld <= 1'b0;
            r_cnt     <= '0;
        end else if (w_gnt_any) begin
            r_vld  <= 1'b1;
            r_data <= w_mux;
            r_src  <= w_gnt_idx;
            r_ptr  <= (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + SRC_W'(1);
            if (r_own_vld && (w_gnt_idx == r_owner)) begin
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_owner   <= w_gnt_idx;
                r_own_vld <= 1'b1;
                r_cnt     <= CNT_W'(1);
            end
        end else begin
            if (r_vld && bus_ready_i) r_vld <= 1'b0;
            if (r_own_vld && !req_i[r_owner]) r_own_vld <= 1'b0;
        end
    end

    assign gnt_o       = w_gnt;
    assign bus_valid_o = r_vld;
    assign bus_data_o  = r_data;
    assign bus_src_o   = r_src;

`ifndef SYNTHESIS
    a_gnt_onehot : assert property (@(posedge clk) $onehot0(gnt_o));
    a_gnt_req    : assert property (@(posedge clk) (gnt_o & ~req_i) == '0);
    a_bus_hold   : assert property (@(posedge clk) disable iff (reset)
                                    (bus_valid_o && !bus_ready_i) |=> $stable(bus_data_o));
`endif
endmodule

// File: doc/shared_bus_arbiter.md
Name: shared_bus_arbiter

Overview:
- Parametrised successor to the per-destination tri-state fan-out: N agents share one internal bus.
- The bus is realised as a registered one-hot AND-OR mux, not as 'z drivers, so contention and floating values cannot occur by construction.
- Round-robin arbitration with an optional burst hold; a valid/ready handshake on the bus side.
- Sits between execution-unit result producers and the common result/bypass bus.

Parameters:
- DATA_WIDTH, 8, width of each agent's data and of the bus.
- NUM_AGENTS, 4, number of requesters (>=2).
- MAX_BURST, 1, max consecutive beats the current owner may keep priority (>=1; 1 = pure round-robin).
- SRC_W, $clog2(NUM_AGENTS), width of the source-id field (derived, not overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_i  in  NUM_AGENTS  per-agent request; agent holds req and data stable until granted.
- data_i  in  NUM_AGENTS*DATA_WIDTH  packed agent data; agent i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt_o  out  NUM_AGENTS  one-hot-or-zero combinational grant; gnt_o[i]=1 means agent i's beat is captured at this edge.
- bus_valid_o  out  1  output register holds a beat.
- bus_data_o  out  DATA_WIDTH  registered bus data.
- bus_src_o  out  SRC_W  index of the agent that produced the current beat.
- bus_ready_i  in  1  consumer accepts the beat when bus_valid_o & bus_ready_i.

Behaviour:
- Reset values:
  - bus_valid_o=0, bus_data_o=0, bus_src_o=0.
  - Priority pointer=0, so agent 0 is highest priority.
  - Burst count=0, owner=none.
  - gnt_o=0 while reset=1, regardless of req_i.
- can_load = !bus_valid_o | bus_ready_i.
- gnt_o = 0 when can_load=0 or req_i=0. Otherwise exactly one bit is set:
  - Burst hold: if owner valid, req_i[owner]=1 and burst count < MAX_BURST, the grant goes to owner.
  - Otherwise the grant goes to the first requesting agent scanning pointer, pointer+1, ... modulo NUM_AGENTS (wrap-around).
- On a grant to agent k:
  - bus_data_o <= data_i[k]; bus_src_o <= k; bus_valid_o <= 1.
  - If k==owner, burst count <= burst count+1; else owner <= k and burst count <= 1.
  - pointer <= (k+1) mod NUM_AGENTS.
- On a consume (bus_valid_o & bus_ready_i) with no grant in the same cycle: bus_valid_o <= 0; data and src retain their values.
- Simultaneous consume and grant: the new beat replaces the old one with no bubble. Full throughput is one beat per cycle.
- Backpressure (bus_valid_o=1, bus_ready_i=0):
  - No grants are issued; the output register holds.
  - Requests are not lost; agents keep req asserted.
- Owner drops req: ownership is released immediately and the next arbitration uses the pointer.
- Latency: one cycle from grant to bus_valid_o.
- Fairness:
  - MAX_BURST=1: any continuously requesting agent is granted within NUM_AGENTS grants.
  - Otherwise: within NUM_AGENTS*MAX_BURST grants.
- Reset asserted mid-transfer: the beat in the output register is discarded (bus_valid_o=0 next cycle), and pointer, owner and count are cleared.
- Assertions:
  - gnt_o is one-hot-or-zero.
  - Any gnt_o bit set implies the matching req_i bit is set.
  - bus_data_o is stable while bus_valid_o & !bus_ready_i.

Test Plan (NUM_AGENTS=4, DATA_WIDTH=8):
- Reset then idle: req_i=0 for 5 cycles -> gnt_o=0, bus_valid_o=0, bus_data_o=0x00, bus_src_o=0.
- MAX_BURST=1, req_i=4'b1111 with data 0xA0..0xA3, bus_ready_i=1 -> grants go to agents 0,1,2,3,0,... one per cycle; bus_src_o sequence 0,1,2,3 each one cycle later.
- MAX_BURST=2, req_i=4'b0101 held -> grant order 0,0,2,2,0,0; bus_data_o follows the same order.
- Backpressure: agent 1 beat 0x55 lands on the bus, bus_ready_i=0 for 3 cycles while req_i=4'b1000 -> gnt_o=0 for those cycles and bus_data_o stays 0x55. When bus_ready_i=1, agent 3 is granted that same cycle and 0x55 is replaced by agent 3's data with no bubble.
- Wrap-around: pointer=3 (after an agent-2 grant), req_i=4'b0011 -> agent 0 granted first, then agent 1.
- Reset mid-operation: bus_valid_o=1 with src 2, reset pulsed for 1 cycle -> bus_valid_o=0 and gnt_o=0 during reset. Next arbitration with req_i=4'b1111 grants agent 0.
